// File: rtl/from_serial_hs.sv
// from_serial_hs
//
// Multi-channel serial-to-parallel deserializer with valid/ready handshakes
// on both sides. RATIO = BW_OUT/BW_IN input beats are collected per channel,
// all channels in lock-step, into one wide word. The word is held in an output
// register until the consumer takes it. The source is stalled only when a
// completing beat would overwrite a word the consumer has not yet accepted.
//
// Optional feature macro: FROM_SERIAL_HS_FLUSH_EN
//   defined   : an accepted beat with s_last=1 always completes the word
//               (unfilled slots zero, m_cnt = beats received, m_last=1);
//               align_err is held at 0.
//   undefined : s_last only reaches m_last on a completing beat; an s_last
//               seen on any other beat sets the sticky align_err flag.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   s_valid    input beat valid
//   s_ready    input beat accepted when s_valid && s_ready
//   s_data     input beat, one BW_IN slice per channel
//   s_last     beat is the final beat of a frame
//   m_valid    output word valid
//   m_ready    consumer accepts word when m_valid && m_ready
//   m_data     assembled word, one BW_OUT slice per channel
//   m_last     word contains the frame's final beat
//   m_cnt      number of valid beats in m_data
//   align_err  sticky frame-misalignment flag

module from_serial_hs #(
    parameter int NO_CH     = 10,
    parameter int BW_IN     = 2,
    parameter int BW_OUT    = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [NO_CH-1:0][BW_IN-1:0]           s_data,
    input  logic                                  s_last,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [NO_CH-1:0][BW_OUT-1:0]          m_data,
    output logic                                  m_last,
    output logic [$clog2(BW_OUT/BW_IN+1)-1:0]     m_cnt,
    output logic                                  align_err
);

    localparam int RATIO = BW_OUT / BW_IN;
    localparam int BCW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int MCW   = $clog2(RATIO + 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(RATIO - 1);

    generate
        if (BW_IN < 1 || BW_OUT < BW_IN || (BW_OUT % BW_IN) != 0) begin : g_bad_ratio
            $error("from_serial_hs: BW_OUT must be a positive integer multiple of BW_IN");
        end
    endgenerate

    typedef enum logic {EMPTY, FULL} out_state_t;

    out_state_t                     state_q, state_d;
    logic [BCW-1:0]                 beat_cnt_q, beat_cnt_d;
    logic [NO_CH-1:0][BW_OUT-1:0]   asm_q, asm_d;
    logic [NO_CH-1:0][BW_OUT-1:0]   m_data_q, m_data_d;
    logic                           m_last_q, m_last_d;
    logic [MCW-1:0]                 m_cnt_q, m_cnt_d;
    logic                           align_err_q, align_err_d;

    logic                           flush_beat;
    logic                           last_slot;
    logic                           accept;
    logic                           complete;
    logic [BCW-1:0]                 slot;
    logic [NO_CH-1:0][BW_OUT-1:0]   merged;

`ifdef FROM_SERIAL_HS_FLUSH_EN
    assign flush_beat = s_last;
`else
    assign flush_beat = 1'b0;
`endif

    // A stall is only needed when this beat would complete a word while the
    // previous word is still waiting for the consumer.
    assign last_slot = (beat_cnt_q == LAST_BEAT);
    assign s_ready   = (state_q == EMPTY) || m_ready || (!last_slot && !flush_beat);
    assign accept    = s_valid && s_ready;
    assign complete  = accept && (last_slot || flush_beat);

    assign slot = (MSB_FIRST != 0) ? (LAST_BEAT - beat_cnt_q) : beat_cnt_q;

    // Current beat merged into the partial word; becomes the output word on
    // a completing beat. Slots not yet written are still zero.
    always_comb begin
        merged = asm_q;
        for (int ch = 0; ch < NO_CH; ch++) begin
            for (int k = 0; k < RATIO; k++) begin
                if (slot == BCW'(k)) begin
                    merged[ch][k*BW_IN +: BW_IN] = s_data[ch];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        asm_d       = asm_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        m_cnt_d     = m_cnt_q;
        align_err_d = align_err_q;

        if (accept) begin
            if (complete) begin
                asm_d      = '0;
                beat_cnt_d = '0;
                m_data_d   = merged;
                m_last_d   = s_last;
                m_cnt_d    = MCW'(beat_cnt_q) + MCW'(1);
            end else begin
                asm_d      = merged;
                beat_cnt_d = beat_cnt_q + BCW'(1);
            end
        end

        // A completing beat reloads the register even while it is being drained.
        if (complete) begin
            state_d = FULL;
        end else if (m_ready) begin
            state_d = EMPTY;
        end

`ifdef FROM_SERIAL_HS_FLUSH_EN
        align_err_d = 1'b0;
`else
        if (accept && s_last && !last_slot) begin
            align_err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            beat_cnt_q  <= '0;
            asm_q       <= '0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            m_cnt_q     <= '0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            asm_q       <= asm_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            m_cnt_q     <= m_cnt_d;
            align_err_q <= align_err_d;
        end
    end

    assign m_valid   = (state_q == FULL);
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign m_cnt     = m_cnt_q;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_from_serial_hs.sv
// tb_from_serial_hs
//
// Drives two from_serial_hs instances (LSB-first and MSB-first, NO_CH=2,
// BW_IN=2, BW_OUT=8) from the same inputs. A table of directed vectors covers
// the documented scenarios, a few hand-written rows cover frame-end handling,
// and a randomized phase is compared against a beat-list reference model.

module tb_from_serial_hs;

    logic clk;
    logic rst;
    logic s_valid;
    logic [1:0][1:0] s_data;
    logic s_last;
    logic m_ready;

    logic loRdy, loMv, loLast, loAlign;
    logic [1:0][7:0] loData;
    logic [2:0] loCnt;
    logic hiRdy, hiMv, hiLast, hiAlign;
    logic [1:0][7:0] hiData;
    logic [2:0] hiCnt;

    int checks = 0;
    int errors = 0;

`ifdef FROM_SERIAL_HS_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    from_serial_hs #(.NO_CH(2), .BW_IN(2), .BW_OUT(8), .MSB_FIRST(0)) dutLo (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(loRdy), .s_data(s_data),
        .s_last(s_last), .m_valid(loMv), .m_ready(m_ready), .m_data(loData),
        .m_last(loLast), .m_cnt(loCnt), .align_err(loAlign)
    );

    from_serial_hs #(.NO_CH(2), .BW_IN(2), .BW_OUT(8), .MSB_FIRST(1)) dutHi (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(hiRdy), .s_data(s_data),
        .s_last(s_last), .m_valid(hiMv), .m_ready(m_ready), .m_data(hiData),
        .m_last(hiLast), .m_cnt(hiCnt), .align_err(hiAlign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       sv;
        logic [1:0] d0;
        logic [1:0] d1;
        logic       last;
        logic       mr;
        logic       expRdy;
        logic       expMv;
        logic       chkData;
        logic [7:0] l0;
        logic [7:0] l1;
        logic [7:0] h0;
        logic [7:0] h1;
        logic [2:0] cnt;
        logic       expLast;
        logic       expAlign;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkRow(input logic r, sv, input logic [1:0] d0, d1,
                                   input logic last, mr, expRdy, expMv, chkData,
                                   input logic [7:0] l0, l1, h0, h1,
                                   input logic [2:0] cnt, input logic expLast, expAlign);
        vec_t v;
        v.rst = r; v.sv = sv; v.d0 = d0; v.d1 = d1; v.last = last; v.mr = mr;
        v.expRdy = expRdy; v.expMv = expMv; v.chkData = chkData;
        v.l0 = l0; v.l1 = l1; v.h0 = h0; v.h1 = h1;
        v.cnt = cnt; v.expLast = expLast; v.expAlign = expAlign;
        return v;
    endfunction

    function automatic void addRow(input logic r, sv, input logic [1:0] d0, d1,
                                   input logic last, mr, expRdy, expMv, chkData,
                                   input logic [7:0] l0, l1, h0, h1,
                                   input logic [2:0] cnt, input logic expLast, expAlign);
        vecs.push_back(mkRow(r, sv, d0, d1, last, mr, expRdy, expMv, chkData,
                             l0, l1, h0, h1, cnt, expLast, expAlign));
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge, well away from the sampling edge.
    task automatic applyStimulus(input logic r, sv, input logic [1:0] d0, d1,
                                 input logic last, mr);
        @(negedge clk);
        rst      = r;
        s_valid  = sv;
        s_data   = {d1, d0};
        s_last   = last;
        m_ready  = mr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic expMv, chkData,
                               input logic [7:0] l0, l1, h0, h1,
                               input logic [2:0] cnt, input logic expLast, expAlign);
        checkVal({tag, ".m_valid_lsb"}, 32'(loMv), 32'(expMv));
        checkVal({tag, ".m_valid_msb"}, 32'(hiMv), 32'(expMv));
        checkVal({tag, ".align_lsb"}, 32'(loAlign), 32'(expAlign));
        checkVal({tag, ".align_msb"}, 32'(hiAlign), 32'(expAlign));
        if (chkData) begin
            checkVal({tag, ".lsb_ch0"}, 32'(loData[0]), 32'(l0));
            checkVal({tag, ".lsb_ch1"}, 32'(loData[1]), 32'(l1));
            checkVal({tag, ".msb_ch0"}, 32'(hiData[0]), 32'(h0));
            checkVal({tag, ".msb_ch1"}, 32'(hiData[1]), 32'(h1));
            checkVal({tag, ".m_cnt_lsb"}, 32'(loCnt), 32'(cnt));
            checkVal({tag, ".m_cnt_msb"}, 32'(hiCnt), 32'(cnt));
            checkVal({tag, ".m_last_lsb"}, 32'(loLast), 32'(expLast));
            checkVal({tag, ".m_last_msb"}, 32'(hiLast), 32'(expLast));
        end
    endtask

    task automatic runRow(input vec_t v, input string tag);
        applyStimulus(v.rst, v.sv, v.d0, v.d1, v.last, v.mr);
        checkVal({tag, ".s_ready_lsb"}, 32'(loRdy), 32'(v.expRdy));
        checkVal({tag, ".s_ready_msb"}, 32'(hiRdy), 32'(v.expRdy));
        @(posedge clk);
        #1;
        checkOutput(tag, v.expMv, v.chkData, v.l0, v.l1, v.h0, v.h1,
                    v.cnt, v.expLast, v.expAlign);
    endtask

    // Reference model: a list of accepted beats per channel; a word is the
    // sum of each beat weighted by its slot position.
    int  qb0[$];
    int  qb1[$];
    bit  mMv;
    bit  mLast;
    bit  mAlign;
    logic [7:0] mL0, mL1, mH0, mH1;
    logic [2:0] mCnt;

    function automatic logic [7:0] buildWord(input int beats[$], input bit msb);
        int w = 0;
        for (int i = 0; i < beats.size(); i++) begin
            int pos = msb ? (3 - i) : i;
            w = w + beats[i] * (1 << (2 * pos));
        end
        return 8'(w);
    endfunction

    task automatic modelReset();
        qb0.delete(); qb1.delete();
        mMv = 0; mLast = 0; mAlign = 0;
        mL0 = 0; mL1 = 0; mH0 = 0; mH1 = 0; mCnt = 0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;

        // Table of directed vectors.
        // LSB/MSB-first word: ch0 1,2,3,0; ch1 3,3,3,3.
        addRow(0,1,2'd1,2'd3,0,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        addRow(0,1,2'd2,2'd3,0,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        addRow(0,1,2'd3,2'd3,0,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        addRow(0,1,2'd0,2'd3,1,1, 1,1,1, 8'h39,8'hFF,8'h6C,8'hFF,3'd4,1,0);
        addRow(0,0,2'd0,2'd0,0,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        // Back-pressure: word 1 (ch0 3,2,1,0; ch1 2s) held with m_ready=0.
        addRow(0,1,2'd3,2'd2,0,0, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        addRow(0,1,2'd2,2'd2,0,0, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        addRow(0,1,2'd1,2'd2,0,0, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        addRow(0,1,2'd0,2'd2,0,0, 1,1,1, 8'h1B,8'hAA,8'hE4,8'hAA,3'd4,0,0);
        // Word 2 (ch0 1s; ch1 0,1,0,1): three beats accepted, fourth stalls.
        addRow(0,1,2'd1,2'd0,0,0, 1,1,1, 8'h1B,8'hAA,8'hE4,8'hAA,3'd4,0,0);
        addRow(0,1,2'd1,2'd1,0,0, 1,1,1, 8'h1B,8'hAA,8'hE4,8'hAA,3'd4,0,0);
        addRow(0,1,2'd1,2'd0,0,0, 1,1,1, 8'h1B,8'hAA,8'hE4,8'hAA,3'd4,0,0);
        addRow(0,1,2'd1,2'd1,0,0, 0,1,1, 8'h1B,8'hAA,8'hE4,8'hAA,3'd4,0,0);
        addRow(0,1,2'd1,2'd1,0,0, 0,1,1, 8'h1B,8'hAA,8'hE4,8'hAA,3'd4,0,0);
        addRow(0,1,2'd1,2'd1,0,1, 1,1,1, 8'h55,8'h44,8'h55,8'h11,3'd4,0,0);
        addRow(0,0,2'd0,2'd0,0,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        // Streaming: 12 beats, m_valid on every 4th edge.
        for (int i = 0; i < 12; i++) begin
            addRow(0,1,2'(i % 4),2'd3,(i % 4) == 3,1, 1,(i % 4) == 3,(i % 4) == 3,
                   8'hE4,8'hFF,8'h1B,8'hFF,3'd4,1,0);
        end
        addRow(0,0,2'd0,2'd0,0,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        // Reset mid-word with a word held and two partial beats.
        addRow(0,1,2'd0,2'd2,0,0, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        addRow(0,1,2'd0,2'd2,0,0, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        addRow(0,1,2'd0,2'd2,0,0, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        addRow(0,1,2'd0,2'd2,0,0, 1,1,1, 8'h00,8'hAA,8'h00,8'hAA,3'd4,0,0);
        addRow(0,1,2'd2,2'd2,0,0, 1,1,1, 8'h00,8'hAA,8'h00,8'hAA,3'd4,0,0);
        addRow(0,1,2'd2,2'd2,0,0, 1,1,1, 8'h00,8'hAA,8'h00,8'hAA,3'd4,0,0);
        addRow(1,1,2'd1,2'd1,0,0, 1,0,1, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        addRow(0,1,2'd3,2'd0,0,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        addRow(0,1,2'd3,2'd0,0,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        addRow(0,1,2'd3,2'd0,0,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);
        addRow(0,1,2'd3,2'd0,0,1, 1,1,1, 8'hFF,8'h00,8'hFF,8'h00,3'd4,0,0);
        addRow(0,0,2'd0,2'd0,0,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0);

        // Initial reset: all outputs zero.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 2'd0, 2'd0, 0, 1);
            @(posedge clk);
            #1;
            checkOutput("reset", 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            runRow(vecs[i], $sformatf("vec%0d", i));
        end

        // Frame end on the 2nd beat of a word.
        runRow(mkRow(1,0,2'd0,2'd0,0,1, 1,0,1, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0), "fl.rst");
        runRow(mkRow(0,1,2'd1,2'd0,0,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0), "fl.b1");
`ifdef FROM_SERIAL_HS_FLUSH_EN
        runRow(mkRow(0,1,2'd2,2'd0,1,0, 1,1,1, 8'h09,8'h00,8'h60,8'h00,3'd2,1,0), "fl.b2");
        // Flush beat against a held, undrained word must stall.
        runRow(mkRow(0,1,2'd3,2'd0,1,0, 0,1,1, 8'h09,8'h00,8'h60,8'h00,3'd2,1,0), "fl.stall");
        runRow(mkRow(0,1,2'd3,2'd0,1,1, 1,1,1, 8'h03,8'h00,8'hC0,8'h00,3'd1,1,0), "fl.one");
        runRow(mkRow(0,0,2'd0,2'd0,0,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,0), "fl.idle");
`else
        runRow(mkRow(0,1,2'd2,2'd0,1,0, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,1), "fl.b2");
        runRow(mkRow(0,1,2'd0,2'd0,0,0, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,1), "fl.b3");
        runRow(mkRow(0,1,2'd0,2'd0,0,0, 1,1,1, 8'h09,8'h00,8'h60,8'h00,3'd4,0,1), "fl.b4");
        runRow(mkRow(0,0,2'd0,2'd0,0,1, 1,0,0, 8'h00,8'h00,8'h00,8'h00,3'd0,0,1), "fl.idle");
`endif

        // Randomized phase against the reference model.
        applyStimulus(1, 0, 2'd0, 2'd0, 0, 1);
        @(posedge clk);
        #1;
        modelReset();
        for (int n = 0; n < 1500; n++) begin
            logic r, sv, last, mr, expRdy, done;
            logic [1:0] d0, d1;
            r    = ($urandom % 64) == 0;
            sv   = ($urandom % 4) != 0;
            d0   = 2'($urandom);
            d1   = 2'($urandom);
            last = ($urandom % 5) == 0;
            mr   = ($urandom % 3) != 0;
            applyStimulus(r, sv, d0, d1, last, mr);
            expRdy = !mMv || mr || (qb0.size() != 3 && !(FLUSH && last));
            checkVal("rnd.s_ready_lsb", 32'(loRdy), 32'(expRdy));
            checkVal("rnd.s_ready_msb", 32'(hiRdy), 32'(expRdy));
            @(posedge clk);
            #1;
            if (r) begin
                modelReset();
            end else begin
                done = 0;
                if (sv && expRdy) begin
                    qb0.push_back(int'(d0));
                    qb1.push_back(int'(d1));
                    if (!FLUSH && last && qb0.size() != 4) mAlign = 1;
                    done = (qb0.size() == 4) || (FLUSH && last);
                end
                if (done) begin
                    mL0 = buildWord(qb0, 0); mL1 = buildWord(qb1, 0);
                    mH0 = buildWord(qb0, 1); mH1 = buildWord(qb1, 1);
                    mCnt = 3'(qb0.size());
                    mLast = last;
                    mMv = 1;
                    qb0.delete(); qb1.delete();
                end else if (mr) begin
                    mMv = 0;
                end
            end
            checkOutput("rnd", mMv, mMv || r, mL0, mL1, mH0, mH1, mCnt, mLast, mAlign);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
